// File: rtl/uart_tx_sequencer_pkg.sv
// Shared definitions for the UART transmit sequencer: register map offsets,
// status bit positions, byte-strobe patterns and the sequencer state encoding.
package uart_tx_sequencer_pkg;

  localparam logic [31:0] DIV_OFF  = 32'd0;
  localparam logic [31:0] DAT_OFF  = 32'd4;
  localparam logic [31:0] CTS_OFF  = 32'd8;
  localparam logic [31:0] STAT_OFF = 32'd12;

  // Bit 0 of the send-status register is 1 while the UART is still shifting.
  localparam int STAT_BUSY_BIT = 0;
  // Bit 0 of the CTS register is 1 while the far end is not clear to send.
  localparam int CTS_BLOCK_BIT = 0;

  localparam logic [3:0] WSTRB_WORD = 4'b1111;
  localparam logic [3:0] WSTRB_BYTE = 4'b0001;
  localparam logic [3:0] WSTRB_READ = 4'b0000;

  typedef enum logic [2:0] {
    ST_CFG,
    ST_IDLE,
    ST_CTS,
    ST_POLL,
    ST_WRITE
  } state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with extra-MSB pointers; push is ignored when full,
// pop is ignored when empty, simultaneous push and pop are both honoured.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic        w_push;
  logic        w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Bus master that programs the UART divisor once, then drains a byte FIFO by
// polling send status and writing each byte. Define UART_CTS_GATE_EN to add a CTS wait.
module uart_tx_sequencer
  import uart_tx_sequencer_pkg::*;
#(
  parameter logic [31:0] ADDR       = 32'h0200_0000,
  parameter logic [31:0] DIVISOR    = 32'd104,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        cfg_done,
  output logic        busy
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_live;
  logic        r_cfg_done;
  logic        r_mem_valid;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic [7:0]  r_byte;

  logic        w_ack;
  logic        w_issue;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_cfg_set;
  logic        w_latch_byte;
  logic [7:0]  w_head;
  logic [31:0] w_req_addr;
  logic [31:0] w_req_wdata;
  logic [3:0]  w_req_wstrb;
  logic        w_unused_rdata;

  assign w_unused_rdata = ^mem_rdata[31:1];

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // r_live holds in_ready and busy low until the first edge after reset release.
  assign w_ack     = r_mem_valid && mem_ready;
  assign in_ready  = r_live && !w_full;
  assign w_push    = in_valid && in_ready;
  assign busy      = r_live && (!w_empty || (r_state != ST_IDLE));
  assign cfg_done  = r_cfg_done;
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_CFG;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A request is launched only while the bus is idle, so an ack always leaves
  // one mem_valid=0 cycle before the next state's request goes out.
  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_req_addr   = ADDR;
    w_req_wdata  = 32'h0;
    w_req_wstrb  = WSTRB_READ;
    w_pop        = 1'b0;
    w_cfg_set    = 1'b0;
    w_latch_byte = 1'b0;
    case (r_state)
      ST_CFG: begin
        w_req_addr  = ADDR + DIV_OFF;
        w_req_wdata = DIVISOR;
        w_req_wstrb = WSTRB_WORD;
        w_issue     = !r_mem_valid;
        if (w_ack) begin
          w_cfg_set   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!w_empty) begin
`ifdef UART_CTS_GATE_EN
          w_state_nxt = ST_CTS;
`else
          w_state_nxt = ST_POLL;
`endif
        end
      end
`ifdef UART_CTS_GATE_EN
      ST_CTS: begin
        w_req_addr = ADDR + CTS_OFF;
        w_issue    = !r_mem_valid;
        if (w_ack && !mem_rdata[CTS_BLOCK_BIT]) w_state_nxt = ST_POLL;
      end
`endif
      ST_POLL: begin
        w_req_addr = ADDR + STAT_OFF;
        w_issue    = !r_mem_valid;
        if (w_ack && !mem_rdata[STAT_BUSY_BIT]) begin
          w_latch_byte = 1'b1;
          w_state_nxt  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_req_addr  = ADDR + DAT_OFF;
        w_req_wdata = {24'h0, r_byte};
        w_req_wstrb = WSTRB_BYTE;
        w_issue     = !r_mem_valid;
        if (w_ack) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_live      <= 1'b0;
      r_cfg_done  <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_wstrb <= 4'h0;
    end else begin
      r_live <= 1'b1;
      if (w_cfg_set) r_cfg_done <= 1'b1;
      if (w_issue) begin
        r_mem_valid <= 1'b1;
        r_mem_addr  <= w_req_addr;
        r_mem_wdata <= w_req_wdata;
        r_mem_wstrb <= w_req_wstrb;
      end else if (w_ack) begin
        r_mem_valid <= 1'b0;
      end
    end
  end

  // Head byte is captured on entry to WRITE so the data word is fixed for the request.
  always_ff @(posedge clk) begin
    if (w_latch_byte) r_byte <= w_head;
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer with a behavioural UART slave that acks
// every request on its second cycle and logs each completed transaction.
module tb_uart_tx_sequencer;

  localparam logic [31:0] A   = 32'h0200_0000;
  localparam logic [31:0] DIV = 32'd104;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h0;
  logic        in_ready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        cfg_done;
  logic        busy;

  int   n_assert = 0;
  int   n_fail   = 0;
  txn_t log_q[$];
  int   cts_at[$];
  int   stat_busy_left = 0;
  int   cts_block_left = 0;
  int   cts_reads = 0;
  bit   hold_write = 1'b0;

  uart_tx_sequencer dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .cfg_done  (cfg_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int count_dat(input int start);
    int c = 0;
    for (int i = start; i < log_q.size(); i++)
      if (log_q[i].addr == A + 32'd4) c++;
    return c;
  endfunction

  task automatic wait_log(input string tag, input int n, input int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, 32'(log_q.size()), 32'(n));
  endtask

  task automatic push(input logic [7:0] d);
    chk("push_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // UART slave: acks on the second cycle of a request, returns status/CTS bits.
  initial begin
    int   cnt;
    bit   ack_pending;
    txn_t t;
    cnt = 0;
    ack_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_pending) begin
        chk("bus_gap", {31'b0, mem_valid}, 32'd0);
        ack_pending = 1'b0;
      end
      mem_ready = 1'b0;
      if (resetn && mem_valid) begin
        cnt++;
        if (cnt >= 2 && !(hold_write && mem_addr == A + 32'd4)) begin
          t.addr  = mem_addr;
          t.wdata = mem_wdata;
          t.wstrb = mem_wstrb;
          t.rdata = 32'h0;
          if (mem_addr == A + 32'd12) begin
            if (stat_busy_left > 0) begin
              t.rdata = 32'h1;
              stat_busy_left--;
            end
          end else if (mem_addr == A + 32'd8) begin
            if (cts_block_left > 0) begin
              t.rdata = 32'h1;
              cts_block_left--;
            end
            cts_reads++;
            cts_at.push_back(log_q.size());
          end
          mem_rdata   = t.rdata;
          mem_ready   = 1'b1;
          ack_pending = 1'b1;
          if (mem_addr != A + 32'd8) log_q.push_back(t);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int base_cts;
    int k;
    int bytes_q[$];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    chk("rst_cfg_done",  {31'b0, cfg_done}, 32'd0);
    chk("rst_busy",      {31'b0, busy}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready}, 32'd0);

    // Divisor write after release
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("cfg_in_ready", {31'b0, in_ready}, 32'd1);
    chk("cfg_busy",     {31'b0, busy}, 32'd1);
    chk("cfg_done_pre", {31'b0, cfg_done}, 32'd0);
    chk("cfg_req_addr", mem_addr, A);
    wait_log("cfg_wait", 1, 50);
    chk("cfg_addr",  log_q[0].addr, A);
    chk("cfg_wdata", log_q[0].wdata, DIV);
    chk("cfg_wstrb", {28'b0, log_q[0].wstrb}, 32'hF);
    chk("cfg_done_post", {31'b0, cfg_done}, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("cfg_quiet_log", 32'(log_q.size()), 32'd1);
    chk("cfg_idle_busy", {31'b0, busy}, 32'd0);

    // Single byte, UART idle
    base = log_q.size();
    push(8'h41);
    wait_log("b41_wait", base + 2, 100);
    chk("b41_poll_addr",  log_q[base].addr, A + 32'd12);
    chk("b41_poll_wstrb", {28'b0, log_q[base].wstrb}, 32'h0);
    chk("b41_wr_addr",    log_q[base+1].addr, A + 32'd4);
    chk("b41_wr_wdata",   log_q[base+1].wdata, 32'h41);
    chk("b41_wr_wstrb",   {28'b0, log_q[base+1].wstrb}, 32'h1);
    chk("b41_busy_after", {31'b0, busy}, 32'd0);

    // UART busy for three polls
    base = log_q.size();
    stat_busy_left = 3;
    push(8'h42);
    wait_log("b42_wait", base + 5, 200);
    for (int i = 0; i < 4; i++) begin
      chk("b42_poll_addr", log_q[base+i].addr, A + 32'd12);
      chk("b42_poll_rd",   log_q[base+i].rdata, (i < 3) ? 32'h1 : 32'h0);
    end
    chk("b42_wr_addr",  log_q[base+4].addr, A + 32'd4);
    chk("b42_wr_wdata", log_q[base+4].wdata, 32'h42);

    // Fill the FIFO while the UART is busy
    base = log_q.size();
    stat_busy_left = 1000;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h10 + 8'(i);
      @(posedge clk); #1;
    end
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    in_data = 8'h14;
    repeat (6) @(posedge clk);
    #1;
    chk("full_hold", {31'b0, in_ready}, 32'd0);
    chk("full_busy", {31'b0, busy}, 32'd1);
    stat_busy_left = 0;
    k = 0;
    while (!in_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("accept_after_pop", 32'(count_dat(base)), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (count_dat(base) < 5 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    chk("fill_dat_count", 32'(count_dat(base)), 32'd5);
    for (int i = base; i < log_q.size(); i++)
      if (log_q[i].addr == A + 32'd4) bytes_q.push_back(int'(log_q[i].wdata));
    for (int i = 0; i < 5; i++)
      chk("fill_order", 32'(bytes_q[i]), 32'h10 + 32'(i));
    chk("fill_busy_after", {31'b0, busy}, 32'd0);

    // CTS gating (CTS blocks for two reads)
    base = log_q.size();
    base_cts = cts_reads;
    cts_block_left = 2;
    push(8'h55);
    wait_log("cts_wait", base + 2, 200);
    chk("cts_poll_addr", log_q[base].addr, A + 32'd12);
    chk("cts_wr_wdata",  log_q[base+1].wdata, 32'h55);
`ifdef UART_CTS_GATE_EN
    chk("cts_read_count", 32'(cts_reads - base_cts), 32'd3);
    for (int i = base_cts; i < cts_reads; i++)
      chk("cts_before_poll", 32'(cts_at[i]), 32'(base));
`else
    chk("cts_never_read", 32'(cts_reads), 32'd0);
`endif

    // Reset asserted while a data write is outstanding
    hold_write = 1'b1;
    push(8'h99);
    k = 0;
    while (!(mem_valid && mem_addr == A + 32'd4) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rstw_write_seen", {31'b0, mem_valid}, 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk("rstw_async_valid", {31'b0, mem_valid}, 32'd0);
    chk("rstw_cfg_done",    {31'b0, cfg_done}, 32'd0);
    chk("rstw_busy",        {31'b0, busy}, 32'd0);
    hold_write = 1'b0;
    base = log_q.size();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    wait_log("rstw_cfg_wait", base + 1, 50);
    chk("rstw_cfg_addr",  log_q[base].addr, A);
    chk("rstw_cfg_wdata", log_q[base].wdata, DIV);
    repeat (30) @(posedge clk);
    #1;
    chk("rstw_quiet_log", 32'(log_q.size()), 32'(base + 1));
    chk("rstw_busy_idle", {31'b0, busy}, 32'd0);
    k = 0;
    for (int i = 0; i < log_q.size(); i++)
      if (log_q[i].addr == A + 32'd4 && log_q[i].wdata == 32'h99) k++;
    chk("rstw_no_discarded", 32'(k), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
- Bus master that owns the memory-mapped UART slave port and streams bytes out through it without CPU involvement.
- After reset it writes the baud divisor once. It then drains an internal byte FIFO.
- For each byte it polls the UART send-status register until idle, then writes the byte to the data register.
- Sits between a byte producer (e.g. the hasher result path) and the UART mem_* port; a system bus mux selects it as the UART master.

Parameters:
- ADDR, 32'h0200_0000, UART base address. ADDR+0 = divisor, +4 = data, +8 = CTS, +12 = send status.
- DIVISOR, 32'd104, value written to the divisor register after reset.
- FIFO_DEPTH, 4, byte FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset
- in_valid  in  1  producer has a byte
- in_data  in  8  byte to send
- in_ready  out  1  FIFO can accept a byte (= !full)
- mem_valid  out  1  bus request to UART
- mem_addr  out  32  request address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte strobes; 0 = read
- mem_ready  in  1  UART acknowledge (uart_ready)
- mem_rdata  in  32  UART read data (uart_rdata)
- cfg_done  out  1  divisor write completed
- busy  out  1  FIFO non-empty or transaction in flight

Behaviour:
- One clock; reset is asynchronous and active-low (clk, resetn).
- Reset values:
  - mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0
  - cfg_done=0, busy=0, in_ready=0
  - FIFO empty; state CFG.
- in_ready=1 from the first cycle after reset release whenever FIFO is not full. Pushes are accepted during CFG.
- Bus rule: all mem_* outputs are registered.
  - mem_valid, mem_addr, mem_wdata and mem_wstrb stay constant from assertion until the cycle mem_ready is sampled high.
  - mem_valid drops the following cycle.
  - At least one idle cycle (mem_valid=0) separates consecutive transactions.
- States:
  - CFG: write addr=ADDR, wdata=DIVISOR, wstrb=4'b1111. On ack: cfg_done<=1, go to IDLE. Entered only from reset.
  - IDLE: if FIFO non-empty, go to POLL (or CTS when the option is compiled in).
  - POLL: read addr=ADDR+12, wstrb=0. On ack:
    - mem_rdata[0]=1 (busy): repeat POLL after the gap cycle.
    - otherwise: go to WRITE.
  - WRITE: write addr=ADDR+4, wdata={24'h0, head byte}, wstrb=4'b0001. On ack: pop the FIFO and return to IDLE. The head byte is sampled at WRITE entry.
- FIFO: read and write pointers of log2(FIFO_DEPTH)+1 bits; wrap modulo 2*FIFO_DEPTH.
  - full when the MSBs differ and the rest are equal; empty when the pointers are equal.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
  - A push is never accepted while full.
- busy = (FIFO not empty) || (state != IDLE). It is 1 during CFG.
- mem_ready is ignored while mem_valid=0.
- Reset asserted mid-transaction:
  - mem_valid drops asynchronously and the FIFO contents are discarded.
  - After release, CFG is re-run before any data write.
- There is no timeout: POLL spins indefinitely while the UART reports busy.

Optional Feature:
- UART_CTS_GATE_EN: when defined, a state CTS is inserted between IDLE and POLL.
  - Reads addr=ADDR+8, wstrb=0.
  - On ack: mem_rdata[0]=0 (clear to send) advances to POLL; 1 repeats CTS after the gap cycle.
- When undefined: no CTS state, and ADDR+8 is never accessed.

Decomposition:
- Shared package holds:
  - register offset constants: DIV_OFF=0, DAT_OFF=4, CTS_OFF=8, STAT_OFF=12
  - the state enum: CFG, IDLE, CTS, POLL, WRITE
  - status bit index constants
- One sub-module: uart_tx_fifo. It is a synchronous byte FIFO parameterised by FIFO_DEPTH, with push, pop, head, full and empty.
- The FSM and bus driver stay in the top module.

Test Plan:
- Reset release with a UART model that acks after 2 cycles -> first transaction is a write to ADDR, data 104, wstrb 1111; cfg_done=1 the cycle after ack; no further bus traffic while the FIFO is empty.
- Push 8'h41 with status=0 -> POLL read of ADDR+12, then write to ADDR+4 with wdata 32'h41 and wstrb 0001; busy returns to 0 after the ack.
- Status model returns busy=1 for 3 polls -> exactly 4 reads of ADDR+12 precede the data write, each separated by an idle cycle.
- Push 5 bytes back-to-back with FIFO_DEPTH=4 while UART busy -> in_ready=0 after 4 pushes; bytes emerge in order 0..3; the 5th byte is accepted once the first pop occurs.
- Assert resetn mid-WRITE -> mem_valid=0 the same cycle without waiting for a clock; after release CFG repeats, and the discarded byte is never written.
- With UART_CTS_GATE_EN and CTS bit 1 for 2 reads -> 3 reads of ADDR+8 precede the POLL read; without the macro, ADDR+8 is never addressed.
